// File: rtl/pcs_tx_scheduler_pkg.sv
// Shared widths and scheduler state encoding for the PCS TX path.
// Lane geometry for the 4-lane distributor this scheduler feeds.
package pcs_tx_scheduler_pkg;

  localparam int UNITWIDTH  = 16;
  localparam int LANENUMBER = 4;
  localparam int DATAW      = UNITWIDTH * LANENUMBER;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } sched_state_e;

endpackage

// File: rtl/pcs_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky flag at the limit.
module pcs_stall_watchdog #(
  parameter int STALL_LIMIT = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_stall,
  input  logic i_clear,
  output logic o_stall_err
);

  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Counter saturates at the limit so a long stall cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_stall && (r_cnt != LIMIT)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_stall && (r_cnt == LIMIT - 1'b1)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_stall_err = r_err;

endmodule

// File: rtl/pcs_tx_scheduler.sv
// Frame-level TX scheduler: show-ahead FIFO to one holding register feeding the lane distributor.
// state  | meaning
// S_IDLE | no frame in flight; waits for a SOF head, discards stray non-SOF words
// S_SEND | frame in flight; streams words until the EOF word is consumed
module pcs_tx_scheduler import pcs_tx_scheduler_pkg::*; #(
  parameter int STALL_LIMIT = 1023,
  parameter int CNTW        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_enable,
  input  logic             in_fifo_empty,
  input  logic [DATAW-1:0] in_fifo_data,
  input  logic             in_fifo_sof,
  input  logic             in_fifo_eof,
  output logic             out_fifo_rd,
  output logic [DATAW-1:0] out_txdata,
  output logic             out_txdata_en,
  input  logic             in_ideal,
  input  logic             in_syncing_pre,
  output logic             out_empty,
  output logic             out_sof_err,
  output logic             out_underrun,
  output logic             out_stall_err,
  output logic [CNTW-1:0]  out_frame_cnt,
  output logic [CNTW-1:0]  out_underrun_cnt
);

  sched_state_e     r_state, w_state_nxt;
  logic             r_valid, w_valid_nxt;
  logic [DATAW-1:0] r_txdata;
  logic             r_eof;
  logic [CNTW-1:0]  r_frame_cnt, r_underrun_cnt;
  logic             w_consume, w_pop, w_load, w_sof_err, w_underrun, w_frame_done;
  logic             w_stall, w_stall_clear;

  assign w_consume = r_valid & in_ideal & in_enable;

  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_sof_err    = 1'b0;
    w_underrun   = 1'b0;
    w_frame_done = 1'b0;
    if (in_enable) begin
      case (r_state)
        S_IDLE: begin
          if (!in_fifo_empty) begin
            if (!in_fifo_sof) begin
              w_pop     = 1'b1;
              w_sof_err = 1'b1;
            end else if (!in_syncing_pre) begin
              w_pop       = 1'b1;
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_consume) begin
            if (r_eof) begin
              w_frame_done = 1'b1;
              // Back-to-back frame only when the distributor is not about to sync.
              if (!in_fifo_empty && in_fifo_sof && !in_syncing_pre) begin
                w_pop       = 1'b1;
                w_load      = 1'b1;
                w_valid_nxt = 1'b1;
              end else begin
                w_valid_nxt = 1'b0;
                w_state_nxt = S_IDLE;
              end
            end else if (!in_fifo_empty) begin
              w_pop       = 1'b1;
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
            end else begin
              w_valid_nxt = 1'b0;
            end
          end else if (!r_valid) begin
            w_underrun = in_ideal;
            if (!in_fifo_empty) begin
              w_pop       = 1'b1;
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_valid        <= 1'b0;
      r_txdata       <= '0;
      r_eof          <= 1'b0;
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_txdata <= in_fifo_data;
        r_eof    <= in_fifo_eof;
      end
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_underrun && (r_underrun_cnt != '1)) r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign w_stall       = r_valid & ~in_ideal & in_enable;
  assign w_stall_clear = in_enable & ~w_stall;

  pcs_stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_stall    (w_stall),
    .i_clear    (w_stall_clear),
    .o_stall_err(out_stall_err)
  );

  // Combinational strobes are held off while reset is asserted so an aborted frame never pops.
  assign out_fifo_rd      = w_pop & reset_n;
  assign out_sof_err      = w_sof_err & reset_n;
  assign out_underrun     = w_underrun & reset_n;
  assign out_txdata_en    = w_consume;
  assign out_txdata       = r_txdata;
  assign out_empty        = (r_state == S_IDLE);
  assign out_frame_cnt    = r_frame_cnt;
  assign out_underrun_cnt = r_underrun_cnt;

endmodule

// File: tb/tb_pcs_tx_scheduler.sv
// Directed bench for pcs_tx_scheduler: FIFO model plus expected-word scoreboard.
module tb_pcs_tx_scheduler;
  import pcs_tx_scheduler_pkg::*;

  typedef struct {
    logic [DATAW-1:0] data;
    logic             sof;
    logic             eof;
  } word_t;

  logic             clk, reset_n, in_enable, in_fifo_empty, in_fifo_sof, in_fifo_eof;
  logic [DATAW-1:0] in_fifo_data, out_txdata;
  logic             out_fifo_rd, out_txdata_en, in_ideal, in_syncing_pre;
  logic             out_empty, out_sof_err, out_underrun, out_stall_err;
  logic [15:0]      out_frame_cnt, out_underrun_cnt;

  pcs_tx_scheduler #(.STALL_LIMIT(8), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable),
    .in_fifo_empty(in_fifo_empty), .in_fifo_data(in_fifo_data),
    .in_fifo_sof(in_fifo_sof), .in_fifo_eof(in_fifo_eof),
    .out_fifo_rd(out_fifo_rd), .out_txdata(out_txdata), .out_txdata_en(out_txdata_en),
    .in_ideal(in_ideal), .in_syncing_pre(in_syncing_pre), .out_empty(out_empty),
    .out_sof_err(out_sof_err), .out_underrun(out_underrun), .out_stall_err(out_stall_err),
    .out_frame_cnt(out_frame_cnt), .out_underrun_cnt(out_underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    n_underrun = 0;
  int    n0;
  word_t fifo_q[$];
  word_t sb_q[$];
  logic  m_inframe = 1'b0;
  logic  s_rd, s_en, s_empty, s_sof_err, s_underrun;
  logic [4:0] exp5_rd, exp5_en, exp5_emp;
  logic [5:0] exp6_rd, exp6_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATAW-1:0] d, input logic sof, input logic eof);
    word_t w;
    w.data = d; w.sof = sof; w.eof = eof;
    fifo_q.push_back(w);
  endtask

  // One clock: present FIFO head, sample at negedge, then apply pop/consume to the models.
  task automatic tick();
    word_t e, h;
    logic  ended, discard;
    ended = 1'b0;
    if (fifo_q.size() > 0) begin
      in_fifo_empty = 1'b0;
      in_fifo_data  = fifo_q[0].data;
      in_fifo_sof   = fifo_q[0].sof;
      in_fifo_eof   = fifo_q[0].eof;
    end else begin
      in_fifo_empty = 1'b1;
      in_fifo_data  = '0;
      in_fifo_sof   = 1'b0;
      in_fifo_eof   = 1'b0;
    end
    @(negedge clk);
    s_rd = out_fifo_rd; s_en = out_txdata_en; s_empty = out_empty;
    s_sof_err = out_sof_err; s_underrun = out_underrun;
    if (s_underrun) n_underrun++;
    if (s_en) begin
      if (sb_q.size() == 0) chk("sb_unexpected_word", {63'd0, s_en}, 64'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_data", out_txdata, e.data);
        ended = e.eof;
      end
    end
    if (ended) m_inframe = 1'b0;
    @(posedge clk);
    if (s_rd) begin
      if (fifo_q.size() == 0) chk("pop_on_empty", {63'd0, s_rd}, 64'd0);
      else begin
        h = fifo_q.pop_front();
        discard = !m_inframe && !h.sof;
        chk("sof_err_vs_model", {63'd0, s_sof_err}, {63'd0, discard});
        if (!discard) begin
          sb_q.push_back(h);
          m_inframe = 1'b1;
        end
      end
    end
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_enable = 1'b1; in_ideal = 1'b1; in_syncing_pre = 1'b0;
    in_fifo_empty = 1'b1; in_fifo_data = '0; in_fifo_sof = 1'b0; in_fifo_eof = 1'b0;
    #12;
    chk("rst_txdata", out_txdata, 64'd0);
    chk("rst_empty", {63'd0, out_empty}, 64'd1);
    chk("rst_en", {63'd0, out_txdata_en}, 64'd0);
    chk("rst_stall", {63'd0, out_stall_err}, 64'd0);
    chk("rst_frames", {48'd0, out_frame_cnt}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 3-word frame
    push(64'hA000_0000_0000_0000, 1, 0);
    push(64'hA000_0000_0000_0001, 0, 0);
    push(64'hA000_0000_0000_0002, 0, 1);
    exp5_rd = 5'b00111; exp5_en = 5'b01110; exp5_emp = 5'b10001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_rd", {63'd0, s_rd}, {63'd0, exp5_rd[i]});
      chk("t1_en", {63'd0, s_en}, {63'd0, exp5_en[i]});
      chk("t1_empty", {63'd0, s_empty}, {63'd0, exp5_emp[i]});
    end
    chk("t1_frames", {48'd0, out_frame_cnt}, 64'd1);

    // two back-to-back 2-word frames
    push(64'hB0, 1, 0); push(64'hB1, 0, 1);
    push(64'hC0, 1, 0); push(64'hC1, 0, 1);
    exp6_rd = 6'b001111; exp6_en = 6'b011110;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_rd", {63'd0, s_rd}, {63'd0, exp6_rd[i]});
      chk("t2_en", {63'd0, s_en}, {63'd0, exp6_en[i]});
    end
    chk("t2_frames", {48'd0, out_frame_cnt}, 64'd3);

    // sync preparation withholds a frame start, but not a frame already running
    in_syncing_pre = 1'b1;
    push(64'hD0, 1, 0); push(64'hD1, 0, 1);
    repeat (3) begin
      tick();
      chk("t3_hold_rd", {63'd0, s_rd}, 64'd0);
      chk("t3_hold_empty", {63'd0, s_empty}, 64'd1);
    end
    in_syncing_pre = 1'b0;
    tick();
    chk("t3_start_rd", {63'd0, s_rd}, 64'd1);
    chk("t3_start_en", {63'd0, s_en}, 64'd0);
    in_syncing_pre = 1'b1;
    tick();
    chk("t3_mid_en", {63'd0, s_en}, 64'd1);
    chk("t3_mid_rd", {63'd0, s_rd}, 64'd1);
    tick();
    chk("t3_last_en", {63'd0, s_en}, 64'd1);
    chk("t3_last_rd", {63'd0, s_rd}, 64'd0);
    in_syncing_pre = 1'b0;
    tick();
    chk("t3_idle_empty", {63'd0, s_empty}, 64'd1);
    chk("t3_frames", {48'd0, out_frame_cnt}, 64'd4);

    // mid-frame underrun: FIFO empty for 5 cycles after word 1
    push(64'hE0, 1, 0);
    tick();
    tick();
    chk("t4_w0_en", {63'd0, s_en}, 64'd1);
    n0 = n_underrun;
    repeat (4) begin
      tick();
      chk("t4_gap_empty", {63'd0, s_empty}, 64'd0);
      chk("t4_gap_en", {63'd0, s_en}, 64'd0);
    end
    push(64'hE1, 0, 0); push(64'hE2, 0, 1);
    tick();
    chk("t4_reload_rd", {63'd0, s_rd}, 64'd1);
    chk("t4_pulses", 64'(n_underrun - n0), 64'd5);
    chk("t4_underrun_cnt", {48'd0, out_underrun_cnt}, 64'd5);
    tick();
    chk("t4_w1_empty", {63'd0, s_empty}, 64'd0);
    tick();
    chk("t4_w2_en", {63'd0, s_en}, 64'd1);
    tick();
    chk("t4_done_empty", {63'd0, s_empty}, 64'd1);
    chk("t4_frames", {48'd0, out_frame_cnt}, 64'd5);

    // non-SOF heads while idle are discarded, also during sync preparation
    push(64'hF0, 0, 0);
    tick();
    chk("t5_rd", {63'd0, s_rd}, 64'd1);
    chk("t5_sof_err", {63'd0, s_sof_err}, 64'd1);
    chk("t5_en", {63'd0, s_en}, 64'd0);
    in_syncing_pre = 1'b1;
    push(64'hF1, 0, 1);
    tick();
    chk("t5_sync_rd", {63'd0, s_rd}, 64'd1);
    chk("t5_sync_sof_err", {63'd0, s_sof_err}, 64'd1);
    in_syncing_pre = 1'b0;
    tick();
    chk("t5_quiet_sof_err", {63'd0, s_sof_err}, 64'd0);
    chk("t5_quiet_en", {63'd0, s_en}, 64'd0);

    // watchdog with STALL_LIMIT=8; disabled cycles must not count
    in_ideal = 1'b0;
    push(64'h1234, 1, 0); push(64'h5678, 0, 1);
    tick();
    repeat (4) tick();
    in_enable = 1'b0;
    repeat (3) begin
      tick();
      chk("t6_dis_rd", {63'd0, s_rd}, 64'd0);
      chk("t6_dis_en", {63'd0, s_en}, 64'd0);
    end
    in_enable = 1'b1;
    repeat (3) tick();
    chk("t6_stall_7", {63'd0, out_stall_err}, 64'd0);
    tick();
    chk("t6_stall_8", {63'd0, out_stall_err}, 64'd1);
    in_ideal = 1'b1;
    tick();
    chk("t6_resume_en", {63'd0, s_en}, 64'd1);
    chk("t6_sticky", {63'd0, out_stall_err}, 64'd1);

    // asynchronous reset mid-frame
    push(64'h9999, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t7_txdata", out_txdata, 64'd0);
    chk("t7_en", {63'd0, out_txdata_en}, 64'd0);
    chk("t7_empty", {63'd0, out_empty}, 64'd1);
    chk("t7_stall", {63'd0, out_stall_err}, 64'd0);
    chk("t7_frames", {48'd0, out_frame_cnt}, 64'd0);
    chk("t7_underrun_cnt", {48'd0, out_underrun_cnt}, 64'd0);
    chk("t7_rd", {63'd0, out_fifo_rd}, 64'd0);
    @(posedge clk); #1;
    repeat (2) begin
      tick();
      chk("t7_rst_rd", {63'd0, s_rd}, 64'd0);
    end
    fifo_q.delete();
    sb_q.delete();
    m_inframe = 1'b0;
    reset_n = 1'b1;

    // single-word frame
    push(64'h0FED_CBA9_8765_4321, 1, 1);
    tick();
    chk("t8_rd", {63'd0, s_rd}, 64'd1);
    tick();
    chk("t8_en", {63'd0, s_en}, 64'd1);
    chk("t8_rd_after", {63'd0, s_rd}, 64'd0);
    chk("t8_frames", {48'd0, out_frame_cnt}, 64'd1);
    tick();
    chk("t8_empty", {63'd0, s_empty}, 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
